// File: rtl/song_sequencer.sv
// Song-playback controller: walks the song table one note per entry, timing each note
// from the beat length (auto mode) or holding it until the learner hits the right key.
module song_sequencer #(
  parameter int unsigned BEAT_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned SONG_LEN    = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       learn,
  input  logic       key_ok,
  output logic [5:0] rom_addr,
  input  logic [4:0] rom_data,
  output logic [2:0] note,
  output logic [6:0] led,
  output logic       note_valid,
  output logic       busy,
  output logic       finished
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] BEAT_LOAD = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES);
  localparam logic [5:0]  END_ADDR  = 6'(SONG_LEN);

  logic [2:0]  state_q, state_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  note_q, note_d;
  logic [6:0]  led_q, led_d;
  logic        note_valid_q, note_valid_d;
  logic        busy_q, busy_d;
  logic        finished_q, finished_d;

  function automatic logic [31:0] note_cycles(input logic [1:0] len);
    logic [31:0] cycles;
    case (len)
      2'd0:    cycles = BEAT_LOAD;
      2'd1:    cycles = BEAT_LOAD << 1;
      2'd2:    cycles = BEAT_LOAD << 2;
      2'd3:    cycles = BEAT_LOAD >> 1;
      default: cycles = BEAT_LOAD;
    endcase
    return cycles;
  endfunction

  function automatic logic [6:0] note_onehot(input logic [2:0] n);
    logic [6:0] oh;
    if (n == 3'd0) begin
      oh = 7'd0;
    end else begin
      oh = 7'b000_0001 << (n - 3'd1);
    end
    return oh;
  endfunction

  // Next-state, address, timer and note selection; stop overrides everything, pause freezes PLAY/GAP.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    timer_d    = timer_q;
    note_d     = 3'd0;
    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = 6'd0;
      timer_d    = 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_FETCH;
            rom_addr_d = 6'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_FETCH: begin
          if (rom_addr_q == END_ADDR) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PLAY;
            note_d  = rom_data[4:2];
            timer_d = note_cycles(rom_data[1:0]);
          end
        end
        S_PLAY: begin
          note_d = note_q;
          if (pause) begin
            state_d = S_PLAY;
          end else if (learn && (note_q != 3'd0)) begin
            // The learner sets the pace: only a correct key ends a sounding note.
            if (key_ok) begin
              state_d = S_GAP;
              note_d  = 3'd0;
              timer_d = GAP_LOAD;
            end else begin
              state_d = S_PLAY;
            end
          end else if (timer_q == 32'd1) begin
            state_d = S_GAP;
            note_d  = 3'd0;
            timer_d = GAP_LOAD;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_GAP: begin
          if (pause) begin
            state_d = S_GAP;
          end else if (timer_q == 32'd1) begin
            state_d    = S_FETCH;
            rom_addr_d = rom_addr_q + 6'd1;
            timer_d    = 32'd0;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        default: begin
          state_d    = S_IDLE;
          rom_addr_d = 6'd0;
          timer_d    = 32'd0;
        end
      endcase
    end
  end

  // Output values follow the next state so they switch on the same edge.
  always_comb begin
    led_d        = note_onehot(note_d);
    note_valid_d = (note_d != 3'd0);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    finished_d   = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= 6'd0;
      timer_q      <= 32'd0;
      note_q       <= 3'd0;
      led_q        <= 7'd0;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      timer_q      <= timer_d;
      note_q       <= note_d;
      led_q        <= led_d;
      note_valid_q <= note_valid_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign note       = note_q;
  assign led        = led_q;
  assign note_valid = note_valid_q;
  assign busy       = busy_q;
  assign finished   = finished_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: 3-entry song, short beat and gap, hand-computed timings.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       learn = 1'b0;
  logic       key_ok = 1'b0;
  logic [5:0] rom_addr;
  logic [4:0] rom_data;
  logic [2:0] note;
  logic [6:0] led;
  logic       note_valid;
  logic       busy;
  logic       finished;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n;
  int t_first;

  song_sequencer #(.BEAT_CYCLES(8), .GAP_CYCLES(2), .SONG_LEN(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .learn(learn), .key_ok(key_ok), .rom_addr(rom_addr), .rom_data(rom_data),
    .note(note), .led(led), .note_valid(note_valid), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  // Song table: {note 5 len 0}, {note 3 len 3}, {rest len 1}
  always_comb begin
    case (rom_addr)
      6'd0:    rom_data = {3'd5, 2'd0};
      6'd1:    rom_data = {3'd3, 2'd3};
      6'd2:    rom_data = {3'd0, 2'd1};
      default: rom_data = 5'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_note"}, 32'(note), 32'd0);
    check_eq({tag, "_led"}, 32'(led), 32'd0);
    check_eq({tag, "_valid"}, 32'(note_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_fin"}, 32'(finished), 32'd0);
    check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // ---------------- auto playback ----------------
    pulse_start();
    check_eq("fetch_busy", 32'(busy), 32'd1);
    check_eq("fetch_addr", 32'(rom_addr), 32'd0);
    check_eq("fetch_valid", 32'(note_valid), 32'd0);
    tick();
    t_first = cyc;
    check_eq("n0_note", 32'(note), 32'd5);
    check_eq("n0_led", 32'(led), 32'b0010000);
    n = 0;
    while (note_valid === 1'b1 && n < 1000) begin n++; tick(); end
    check_eq("n0_len", 32'(n), 32'd8);
    check_eq("gap0_note", 32'(note), 32'd0);
    check_eq("gap0_led", 32'(led), 32'd0);
    check_eq("gap0_addr", 32'(rom_addr), 32'd0);
    tick(); tick();
    check_eq("fetch1_addr", 32'(rom_addr), 32'd1);
    check_eq("fetch1_valid", 32'(note_valid), 32'd0);
    tick();
    check_eq("n1_note", 32'(note), 32'd3);
    check_eq("n1_led", 32'(led), 32'b0000100);
    n = 0;
    while (note_valid === 1'b1 && n < 1000) begin n++; tick(); end
    check_eq("n1_len", 32'(n), 32'd4);
    tick(); tick(); tick();
    check_eq("rest_addr", 32'(rom_addr), 32'd2);
    check_eq("rest_valid", 32'(note_valid), 32'd0);
    check_eq("rest_busy", 32'(busy), 32'd1);
    // rest plays 16 cycles then gaps 2 cycles, all at address 2
    n = 0;
    while (rom_addr == 6'd2 && n < 1000) begin n++; tick(); end
    check_eq("rest_len", 32'(n), 32'd18);
    check_eq("end_fetch_addr", 32'(rom_addr), 32'd3);
    check_eq("end_fetch_fin", 32'(finished), 32'd0);
    tick();
    check_eq("done_fin", 32'(finished), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_addr", 32'(rom_addr), 32'd3);
    // 8 + 2 gap + 1 fetch + 4 + 2 + 1 + 16 + 2 + final fetch 1
    check_eq("song_period", 32'(cyc - t_first), 32'd37);
    tick(); tick();
    check_eq("done_hold", 32'(finished), 32'd1);

    // ---------------- restart from DONE ----------------
    pulse_start();
    check_eq("restart_addr", 32'(rom_addr), 32'd0);
    check_eq("restart_fin", 32'(finished), 32'd0);
    tick();
    check_eq("restart_note", 32'(note), 32'd5);
    pulse_stop();
    check_all_zero("stop_play");

    // ---------------- pause ----------------
    pulse_start();
    tick();
    n = 0;
    while (note_valid === 1'b1 && n < 1000) begin
      n++;
      if (n == 3) pause = 1'b1;
      if (n == 6) check_eq("pause_addr", 32'(rom_addr), 32'd0);
      if (n == 8) pause = 1'b0;
      tick();
    end
    check_eq("pause_len", 32'(n), 32'd13);

    // ---------------- stop during GAP ----------------
    check_eq("gap_busy", 32'(busy), 32'd1);
    pulse_stop();
    check_all_zero("stop_gap");

    // ---------------- stop + pause ----------------
    pulse_start();
    tick();
    stop = 1'b1;
    pause = 1'b1;
    tick();
    stop = 1'b0;
    pause = 1'b0;
    check_all_zero("stop_pause");

    // ---------------- start while busy ----------------
    pulse_start();
    tick();
    n = 0;
    while (note_valid === 1'b1 && n < 1000) begin
      n++;
      start = (n == 3);
      tick();
    end
    start = 1'b0;
    check_eq("busy_start_len", 32'(n), 32'd8);
    check_eq("busy_start_addr", 32'(rom_addr), 32'd0);
    pulse_stop();

    // ---------------- learn mode ----------------
    learn = 1'b1;
    pulse_start();
    tick();
    repeat (100) tick();
    check_eq("learn_hold_valid", 32'(note_valid), 32'd1);
    check_eq("learn_hold_note", 32'(note), 32'd5);
    key_ok = 1'b1;
    tick();
    key_ok = 1'b0;
    check_eq("learn_key_valid", 32'(note_valid), 32'd0);
    check_eq("learn_key_addr", 32'(rom_addr), 32'd0);
    tick(); tick(); tick();
    check_eq("learn_n1_note", 32'(note), 32'd3);
    pause = 1'b1;
    key_ok = 1'b1;
    tick();
    key_ok = 1'b0;
    tick();
    pause = 1'b0;
    tick();
    check_eq("learn_paused_key", 32'(note_valid), 32'd1);
    key_ok = 1'b1;
    tick();
    key_ok = 1'b0;
    check_eq("learn_n1_end", 32'(note_valid), 32'd0);
    tick(); tick(); tick();
    check_eq("learn_rest_addr", 32'(rom_addr), 32'd2);
    n = 0;
    while (rom_addr == 6'd2 && n < 1000) begin n++; tick(); end
    check_eq("learn_rest_len", 32'(n), 32'd18);
    tick();
    check_eq("learn_done", 32'(finished), 32'd1);
    learn = 1'b0;
    pulse_stop();

    // ---------------- async reset mid-PLAY ----------------
    pulse_start();
    tick();
    check_eq("pre_rst_valid", 32'(note_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_valid", 32'(note_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
